// File: rtl/multi_key_filter_pkg.sv
// Shared definitions for the multi-key debounce filter: per-channel FSM
// encoding, default timing constants and a counter-sizing helper.
package multi_key_filter_pkg;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'b0001,
    ST_FILTER0 = 4'b0010,
    ST_DOWN    = 4'b0100,
    ST_FILTER1 = 4'b1000
  } kstate_e;

  localparam int DEF_NUM_KEYS      = 4;
  localparam int DEF_DEB_CYCLES    = 1_000_000;
  localparam int DEF_LONG_CYCLES   = 50_000_000;
  localparam int DEF_REPEAT_CYCLES = 10_000_000;
  localparam int DEF_REPEAT_EN     = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/multi_key_filter_key_chan.sv
// One key channel: 2-flop synchronizer, press/release debounce FSM and
// long-press / auto-repeat hold timer. All outputs are registered.
module key_chan
  import multi_key_filter_pkg::*;
#(
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int REPEAT_EN     = DEF_REPEAT_EN
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int CW = $clog2(max3(DEB_CYCLES, LONG_CYCLES, REPEAT_CYCLES)) + 1;
  localparam logic [CW-1:0] DEB_C  = CW'(DEB_CYCLES);
  localparam logic [CW-1:0] LONG_C = CW'(LONG_CYCLES);
  localparam logic [CW-1:0] REP_C  = CW'(REPEAT_CYCLES);
  localparam logic [CW-1:0] ONE_C  = CW'(1);

  logic [1:0]    r_sync;
  logic          w_s;
  kstate_e       r_st, w_st_nxt;
  logic [CW-1:0] r_deb, w_deb_nxt, w_deb_inc;
  logic [CW-1:0] r_hold, w_hold_nxt, w_hold_inc;
  logic          r_flag, w_flag_nxt;
  logic          r_state, w_state_nxt;
  logic          r_press, w_press_nxt;
  logic          r_rel, w_rel_nxt;
  logic          r_long, w_long_nxt;

  assign w_s        = r_sync[1];
  assign w_deb_inc  = r_deb + ONE_C;
  assign w_hold_inc = r_hold + ONE_C;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync  <= 2'b11;
      r_st    <= ST_IDLE;
      r_deb   <= '0;
      r_hold  <= '0;
      r_flag  <= 1'b0;
      r_state <= 1'b1;
      r_press <= 1'b0;
      r_rel   <= 1'b0;
      r_long  <= 1'b0;
    end else begin
      r_sync  <= {r_sync[0], key_n};
      r_st    <= w_st_nxt;
      r_deb   <= w_deb_nxt;
      r_hold  <= w_hold_nxt;
      r_flag  <= w_flag_nxt;
      r_state <= w_state_nxt;
      r_press <= w_press_nxt;
      r_rel   <= w_rel_nxt;
      r_long  <= w_long_nxt;
    end
  end

  // The ">=" compares keep a timing constant of 1 from stalling a counter.
  always_comb begin
    w_st_nxt    = r_st;
    w_deb_nxt   = r_deb;
    w_hold_nxt  = r_hold;
    w_flag_nxt  = r_flag;
    w_state_nxt = r_state;
    w_press_nxt = 1'b0;
    w_rel_nxt   = 1'b0;
    w_long_nxt  = 1'b0;
    case (r_st)
      ST_IDLE: begin
        if (!w_s) begin
          w_st_nxt  = ST_FILTER0;
          w_deb_nxt = ONE_C;
        end
      end
      ST_FILTER0: begin
        if (w_s) begin
          w_st_nxt  = ST_IDLE;
          w_deb_nxt = '0;
        end else if (w_deb_inc >= DEB_C) begin
          w_st_nxt    = ST_DOWN;
          w_deb_nxt   = '0;
          w_hold_nxt  = '0;
          w_flag_nxt  = 1'b0;
          w_state_nxt = 1'b0;
          w_press_nxt = 1'b1;
        end else begin
          w_deb_nxt = w_deb_inc;
        end
      end
      ST_DOWN: begin
        if (w_s) begin
          w_st_nxt  = ST_FILTER1;
          w_deb_nxt = ONE_C;
        end else if (!r_flag) begin
          if (w_hold_inc >= LONG_C) begin
            w_long_nxt = 1'b1;
            w_flag_nxt = 1'b1;
            w_hold_nxt = '0;
          end else begin
            w_hold_nxt = w_hold_inc;
          end
        end else if (REPEAT_EN != 0) begin
          if (w_hold_inc >= REP_C) begin
            w_long_nxt = 1'b1;
            w_hold_nxt = '0;
          end else begin
            w_hold_nxt = w_hold_inc;
          end
        end
      end
      ST_FILTER1: begin
        // Hold timer and long flag are frozen here so a release bounce
        // resumes long-press timing where it left off.
        if (!w_s) begin
          w_st_nxt  = ST_DOWN;
          w_deb_nxt = '0;
        end else if (w_deb_inc >= DEB_C) begin
          w_st_nxt    = ST_IDLE;
          w_deb_nxt   = '0;
          w_hold_nxt  = '0;
          w_flag_nxt  = 1'b0;
          w_state_nxt = 1'b1;
          w_rel_nxt   = 1'b1;
        end else begin
          w_deb_nxt = w_deb_inc;
        end
      end
      default: begin
        w_st_nxt  = ST_IDLE;
        w_deb_nxt = '0;
      end
    endcase
  end

  assign key_state   = r_state;
  assign key_press   = r_press;
  assign key_release = r_rel;
  assign key_long    = r_long;

endmodule

// File: rtl/multi_key_filter.sv
// NUM_KEYS independent debounced key channels plus a registered
// "something happened last cycle" flag.
module multi_key_filter
  import multi_key_filter_pkg::*;
#(
  parameter int NUM_KEYS      = DEF_NUM_KEYS,
  parameter int DEB_CYCLES    = DEF_DEB_CYCLES,
  parameter int LONG_CYCLES   = DEF_LONG_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES,
  parameter int REPEAT_EN     = DEF_REPEAT_EN
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_KEYS-1:0] key_in,
  output logic [NUM_KEYS-1:0] key_state,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic [NUM_KEYS-1:0] key_long,
  output logic                any_event
);

  logic [NUM_KEYS-1:0] w_state, w_press, w_rel, w_long;
  logic                r_any;

  for (genvar gi = 0; gi < NUM_KEYS; gi++) begin : g_chan
    key_chan #(
      .DEB_CYCLES   (DEB_CYCLES),
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .REPEAT_EN    (REPEAT_EN)
    ) u_chan (
      .clk        (clk),
      .rst        (rst),
      .key_n      (key_in[gi]),
      .key_state  (w_state[gi]),
      .key_press  (w_press[gi]),
      .key_release(w_rel[gi]),
      .key_long   (w_long[gi])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_any <= 1'b0;
    else     r_any <= |{w_press, w_rel, w_long};
  end

  assign key_state   = w_state;
  assign key_press   = w_press;
  assign key_release = w_rel;
  assign key_long    = w_long;
  assign any_event   = r_any;

endmodule

// File: tb/tb_multi_key_filter.sv
// Directed bench for multi_key_filter with short timing constants.
module tb_multi_key_filter;

  localparam int NK = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [NK-1:0] key_in = '1;
  logic [NK-1:0] key_state, key_press, key_release, key_long;
  logic          any_event;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int viol  = 0;
  int cnt_press[NK], cnt_rel[NK], cnt_long[NK];
  int press_cyc[NK], rel_cyc[NK];
  int long_cyc[NK][8];
  logic [NK-1:0] prv_press = '0, prv_rel = '0, prv_long = '0;

  multi_key_filter #(
    .NUM_KEYS(NK), .DEB_CYCLES(8), .LONG_CYCLES(32),
    .REPEAT_CYCLES(8), .REPEAT_EN(1)
  ) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_state(key_state),
    .key_press(key_press), .key_release(key_release),
    .key_long(key_long), .any_event(any_event)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    for (int i = 0; i < NK; i++) begin
      cnt_press[i] = 0; cnt_rel[i] = 0; cnt_long[i] = 0;
      press_cyc[i] = 0; rel_cyc[i] = 0;
      for (int j = 0; j < 8; j++) long_cyc[i][j] = 0;
    end
  end

  // Event recorder plus pulse-width / press-long exclusivity watch.
  always @(negedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NK; i++) begin
        if (key_press[i])   begin cnt_press[i]++; press_cyc[i] = cyc; end
        if (key_release[i]) begin cnt_rel[i]++;   rel_cyc[i]   = cyc; end
        if (key_long[i]) begin
          if (cnt_long[i] < 8) long_cyc[i][cnt_long[i]] = cyc;
          cnt_long[i]++;
        end
        if (key_press[i] && key_long[i]) viol++;
        if ((key_press[i] && prv_press[i]) || (key_release[i] && prv_rel[i]) ||
            (key_long[i] && prv_long[i])) viol++;
      end
    end
    prv_press = key_press; prv_rel = key_release; prv_long = key_long;
  end

  initial begin
    #100us;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  int c, c2, pp, rr, ll;

  initial begin
    // Reset values
    step(3);
    chk("rst_state",   32'(key_state),   32'hF);
    chk("rst_press",   32'(key_press),   32'h0);
    chk("rst_release", 32'(key_release), 32'h0);
    chk("rst_long",    32'(key_long),    32'h0);
    chk("rst_any",     32'(any_event),   32'h0);
    rst = 1'b0;
    step(3);

    // Clean press and release on channel 0
    c = cyc; key_in[0] = 1'b0;
    step(14);
    chk("clean_press_lat", 32'(press_cyc[0] - c), 32'd10);
    chk("clean_press_cnt", 32'(cnt_press[0]), 32'd1);
    chk("clean_state0",    32'(key_state[0]), 32'd0);
    chk("clean_no_rel",    32'(cnt_rel[0]), 32'd0);
    c = cyc; key_in[0] = 1'b1;
    step(14);
    chk("clean_rel_lat",   32'(rel_cyc[0] - c), 32'd10);
    chk("clean_rel_cnt",   32'(cnt_rel[0]), 32'd1);
    chk("clean_state1",    32'(key_state[0]), 32'd1);

    // Short bounce on channel 1
    key_in[1] = 1'b0; step(5);
    key_in[1] = 1'b1; step(15);
    chk("bounce_no_press", 32'(cnt_press[1]), 32'd0);
    chk("bounce_state",    32'(key_state[1]), 32'd1);

    // Long press with auto-repeat on channel 2
    c = cyc; key_in[2] = 1'b0;
    step(70);
    key_in[2] = 1'b1;
    step(14);
    chk("long_press_cnt", 32'(cnt_press[2]), 32'd1);
    chk("long_press_lat", 32'(press_cyc[2] - c), 32'd10);
    chk("long_first",     32'(long_cyc[2][0] - press_cyc[2]), 32'd32);
    chk("long_rep1",      32'(long_cyc[2][1] - press_cyc[2]), 32'd40);
    chk("long_rep2",      32'(long_cyc[2][2] - press_cyc[2]), 32'd48);
    chk("long_cnt",       32'(cnt_long[2]), 32'd4);
    chk("long_rel_cnt",   32'(cnt_rel[2]), 32'd1);

    // Release bounce on channel 0
    key_in[0] = 1'b0; step(14);
    rr = cnt_rel[0];
    key_in[0] = 1'b1; step(3);
    key_in[0] = 1'b0; step(2);
    c = cyc; key_in[0] = 1'b1; step(20);
    chk("relb_one_rel", 32'(cnt_rel[0] - rr), 32'd1);
    chk("relb_rel_lat", 32'(rel_cyc[0] - c), 32'd10);
    chk("relb_no_long", 32'(cnt_long[0]), 32'd0);
    chk("relb_state",   32'(key_state[0]), 32'd1);

    // Simultaneous press on all channels
    key_in = 4'b0000;
    step(10);
    @(negedge clk); #1;
    chk("sim_press_all", 32'(key_press), 32'hF);
    chk("sim_any_early", 32'(any_event), 32'h0);
    @(negedge clk); #1;
    chk("sim_press_gone", 32'(key_press), 32'h0);
    chk("sim_any_next",   32'(any_event), 32'h1);
    chk("sim_state",      32'(key_state), 32'h0);
    key_in = 4'b1111;
    step(14);
    chk("sim_rel_state", 32'(key_state), 32'hF);

    // Reset mid-hold on channel 0, key kept low through reset
    c = cyc; key_in[0] = 1'b0;
    step(30);
    chk("rmh_pressed", 32'(press_cyc[0] - c), 32'd10);
    pp = cnt_press[0]; rr = cnt_rel[0]; ll = cnt_long[0];
    rst = 1'b1; #1;
    chk("rmh_async_state", 32'(key_state), 32'hF);
    chk("rmh_async_press", 32'(key_press | key_long | key_release), 32'h0);
    step(3);
    rst = 1'b0; c2 = cyc;
    step(30);
    chk("rmh_repress_lat", 32'(press_cyc[0] - c2), 32'd10);
    chk("rmh_repress_cnt", 32'(cnt_press[0] - pp), 32'd1);
    chk("rmh_no_long",     32'(cnt_long[0] - ll), 32'd0);
    chk("rmh_no_rel",      32'(cnt_rel[0] - rr), 32'd0);
    chk("rmh_state",       32'(key_state[0]), 32'd0);
    key_in[0] = 1'b1;
    step(14);

    chk("pulse_rules", 32'(viol), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
